nbit_add_sub_accum: RTL and testbench

NBIT_ADD_SUB_ACCUM -- requirements
Module: nbit_add_sub_accum

---
 rtl/nbit_add_sub_pkg.sv | 19 +
 rtl/add_sub_result_ext.sv | 23 ++
 rtl/nbit_add_sub_accum.sv | 109 ++++++++++
 tb/tb_nbit_add_sub_accum.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/nbit_add_sub_pkg.sv
// Shared types and width helpers for the add/sub result accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nbit_add_sub_pkg;

   // Batch FSM encoding; 2'd3 is left unused and treated as illegal.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } acc_state_e;

   // Accumulator width: the N+1 bit result plus CNT_W bits of headroom,
   // enough to sum up to 2^CNT_W-1 results without overflow.
   function automatic int acc_width(input int n, input int cnt_w);
      return n + 1 + cnt_w;
   endfunction

endpackage

// File: rtl/add_sub_result_ext.sv
// Widens an N+1 bit add/sub result to the accumulator width.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module add_sub_result_ext #(
   parameter int N     = 64,
   parameter int OUT_W = 73
) (
   input  logic [N:0]       s_in,
   input  logic             k_in,
   output logic [OUT_W-1:0] ext_out
);

   // Add results are unsigned magnitudes; subtract results carry a sign in bit N.
   always_comb begin
      ext_out = '0;
      if (k_in) begin
         ext_out = {{(OUT_W-N-1){s_in[N]}}, s_in};
      end else begin
         ext_out = {{(OUT_W-N-1){1'b0}}, s_in};
      end
   end

endmodule

// File: rtl/nbit_add_sub_accum.sv
// Sums batches of up to BATCH add/sub results and presents each signed total.
// Latency: total is on acc_out the cycle after the closing accept or flush.
// Backpressure: in_ready drops while a total waits; held until out_ready.
module nbit_add_sub_accum
   import nbit_add_sub_pkg::*;
#(
   parameter int N     = 64,
   parameter int CNT_W = 8,
   parameter int BATCH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N:0]             s_in,
   input  logic                   k_in,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N+CNT_W:0]       acc_out,
   output logic [CNT_W-1:0]       out_count
);

   localparam int ACC_W = acc_width(N, CNT_W);
   localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

   acc_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [ACC_W-1:0] s_ext;
   logic             accept;
   logic [CNT_W-1:0] count_inc;

   add_sub_result_ext #(
      .N     (N),
      .OUT_W (ACC_W)
   ) u_ext (
      .s_in    (s_in),
      .k_in    (k_in),
      .ext_out (s_ext)
   );

   // Handshake and outputs depend only on registered state, so no comb loop
   // is formed with upstream or downstream logic.
   always_comb begin
      in_ready  = (state_q == IDLE) || (state_q == ACCUM);
      out_valid = (state_q == DRAIN);
      accept    = in_valid && in_ready;
      count_inc = count_q + CNT_W'(1);
      acc_out   = acc_q;
      out_count = count_q;
   end

   // Next-state: fold in accepted results, close on full batch or flush,
   // clear on drain handshake.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            // A lone flush with nothing accepted has no batch to close.
            if (accept) begin
               acc_d   = acc_q + s_ext;
               count_d = count_inc;
               state_d = (flush || count_inc == BATCH_C) ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_d   = acc_q + s_ext;
               count_d = count_inc;
               if (count_inc == BATCH_C) begin
                  state_d = DRAIN;
               end
            end
            if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               count_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
         end
      endcase
   end

   // State registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_nbit_add_sub_accum.sv
// Directed-vector bench for the batch accumulator (N=8, CNT_W=4, BATCH=4).
// Latency: checks one cycle after each closing accept or flush.
// Backpressure: exercises held totals with out_ready low.
module tb_nbit_add_sub_accum;

   localparam int N     = 8;
   localparam int CNT_W = 4;
   localparam int BATCH = 4;
   localparam int ACC_W = N + 1 + CNT_W;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [N:0]       s_in;
   logic             k_in;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic [CNT_W-1:0] out_count;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   nbit_add_sub_accum #(
      .N     (N),
      .CNT_W (CNT_W),
      .BATCH (BATCH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s_in      (s_in),
      .k_in      (k_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .out_count (out_count)
   );

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs and checks happen 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [N:0] s, input logic k, input logic f);
      in_valid = v;
      s_in     = s;
      k_in     = k;
      flush    = f;
   endtask

   task automatic idle_inputs();
      drive(1'b0, '0, 1'b0, 1'b0);
      out_ready = 1'b0;
   endtask

   task automatic check_total(input string tag, input logic [ACC_W-1:0] acc, input logic [CNT_W-1:0] cnt);
      check_vec({tag, "_vld"}, 32'(out_valid), 32'd1);
      check_vec({tag, "_rdy"}, 32'(in_ready), 32'd0);
      check_vec({tag, "_acc"}, 32'(acc_out), 32'(acc));
      check_vec({tag, "_cnt"}, 32'(out_count), 32'(cnt));
   endtask

   task automatic check_idle(input string tag);
      check_vec({tag, "_vld"}, 32'(out_valid), 32'd0);
      check_vec({tag, "_rdy"}, 32'(in_ready), 32'd1);
      check_vec({tag, "_acc"}, 32'(acc_out), 32'd0);
      check_vec({tag, "_cnt"}, 32'(out_count), 32'd0);
   endtask

   task automatic drain_total();
      idle_inputs();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset");

      // Four add results of 256.
      drive(1'b1, 9'h100, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      check_vec("add3_vld", 32'(out_valid), 32'd0);
      check_vec("add3_cnt", 32'(out_count), 32'd3);
      tick();
      idle_inputs();
      check_total("add4", 13'd1024, 4'd4);
      drain_total();
      check_idle("add4_drained");

      // Four subtract results of -1.
      drive(1'b1, 9'h1FF, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      idle_inputs();
      check_total("sub4", 13'h1FFC, 4'd4);
      drain_total();

      // 5 + (-3) then flush with 7 in the same cycle -> 9 over 3 results.
      drive(1'b1, 9'd5, 1'b0, 1'b0);
      tick();
      drive(1'b1, 9'h1FD, 1'b1, 1'b0);
      tick();
      drive(1'b1, 9'd7, 1'b0, 1'b1);
      tick();
      drive(1'b1, 9'd1, 1'b0, 1'b0);
      check_total("flush3", 13'd9, 4'd3);

      // Hold the total for 5 cycles with in_valid high: nothing accepted.
      for (int i = 0; i < 5; i++) begin
         tick();
         check_total("hold", 13'd9, 4'd3);
      end
      // Drain with in_valid still high: the input must be ignored.
      out_ready = 1'b1;
      tick();
      idle_inputs();
      check_idle("hold_drained");

      // Reset after two accepts discards the partial batch.
      drive(1'b1, 9'd1, 1'b0, 1'b0);
      tick();
      tick();
      check_vec("part2_cnt", 32'(out_count), 32'd2);
      rst       = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 9'd1, 1'b0, 1'b1);
      tick();
      rst = 1'b0;
      idle_inputs();
      check_idle("rst_mid");
      drive(1'b1, 9'd1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      idle_inputs();
      check_total("ones4", 13'd4, 4'd4);

      // Reset while a total is pending: it is dropped.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_drain");

      // Flush in IDLE without an accept is ignored.
      drive(1'b0, 9'd0, 1'b0, 1'b1);
      tick();
      tick();
      idle_inputs();
      check_idle("flush_idle");

      // Flush with an accept in IDLE closes a 1-element batch of -2.
      drive(1'b1, 9'h1FE, 1'b1, 1'b1);
      tick();
      idle_inputs();
      check_total("single", 13'h1FFE, 4'd1);
      drain_total();
      check_idle("single_drained");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
